vga_square_grid: RTL and testbench
==================================

# vga_square_grid

Parametrised square-overlay renderer for the VGA pixel path. It draws a GRID_COLS × GRID_ROWS grid of filled squares, each with its own colour, and supports optional per-square blinking. Colour changes are double-buffered so they apply only at frame boundaries. It sits between the VGA timing generator (pixel_row/pixel_col/frame_start) and the DAC/output pins. It replaces the fixed four-square, single-colour, purely combinational overlay.

## Interface
- GRID_COLS, 2, squares per row.
- GRID_ROWS, 2, squares per column; N = GRID_COLS*GRID_ROWS.
- HSQ_SIZE, 100, half side length in pixels.
- ORIGIN_X, 160, centre column of square 0.
- ORIGIN_Y, 120, centre row of square 0.
- PITCH_X, 300, horizontal centre spacing.
- PITCH_Y, 220, vertical centre spacing.
- CH_W, 1, bits per colour channel.
- BLINK_FRAMES, 30, frames per blink half-period (≥1).
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous, active-low reset.
- pixel_row  in  11  current row.
- pixel_col  in  11  current column.
- pixel_valid  in  1  the row/col pair is in the active area.
- frame_start  in  1  one-cycle pulse at start of frame.
- squares  in  N  per-square enable; bit i is square i.
- cfg_we  in  1  write strobe for the shadow colour table.
- cfg_idx  in  max(1,$clog2(N))  square index to write; ignored if ≥N.
- cfg_color  in  3*CH_W  {r,g,b} colour for cfg_idx.
- cfg_blink  in  1  blink enable for cfg_idx.
- red, green, blue  out  CH_W each  pixel colour.
- rgb_valid  out  1  pixel_valid delayed by pipeline latency.

## Operation
- Square i = r*GRID_COLS + c. Centre is cx = ORIGIN_X + c*PITCH_X, cy = ORIGIN_Y + r*PITCH_Y. Defaults reproduce the legacy 160/460 × 120/340 layout.
- Hit test is inclusive. Column hit: pixel_col + HSQ_SIZE ≥ cx AND pixel_col ≤ cx + HSQ_SIZE. Row hit is the same with pixel_row and cy. Arithmetic is 12-bit unsigned, so no wrap or underflow occurs. The pixel is drawn when both hits are true.
- Square i is visible when: hit_i AND squares[i] AND NOT (blink_i AND blink_phase).
- When squares overlap, the lowest visible index wins. There is no OR-blending.
- Output colour is the committed colour of the winner. It is 0 when there is no winner or when the delayed pixel_valid is 0.
- Colour table is double-buffered:
  - cfg_we writes cfg_color and cfg_blink into shadow[cfg_idx] on the same edge. One write is accepted per cycle and the port is always ready.
  - On frame_start, the whole shadow table is copied into the committed table.
  - If cfg_we and frame_start occur in the same cycle, the new write is forwarded into committed[cfg_idx].
- Blink: frame_cnt counts frame_start pulses from 0 to BLINK_FRAMES-1, then wraps to 0 and toggles blink_phase.

## Timing
- Latency is 2 cycles from pixel_row/pixel_col/pixel_valid to red/green/blue/rgb_valid.
  - Stage 1 registers the N hit bits and valid.
  - Stage 2 registers the priority select and colour lookup.
- squares is sampled in stage 1. The committed table and blink_phase are read in stage 2.
- A committed-table update takes effect on the first pixel whose stage 2 falls after the frame_start edge.
- Reset values:
  - red, green, blue = 0; rgb_valid = 0.
  - Shadow and committed colours are all-ones (white), with blink = 0.
  - frame_cnt = 0; blink_phase = 0; pipeline valids = 0.
- On assertion, reset takes effect immediately. On reset mid-frame, outputs go to 0 asynchronously. Fresh data emerges 2 cycles after release.

## Configuration
- VGA_SQ_BLINK_EN defined: frame_cnt and blink_phase are built and blink bits act as described above.
- VGA_SQ_BLINK_EN undefined: cfg_blink is ignored, there is no blink storage or counter, and every enabled square is always visible.

## Structure
- Package vga_sq_pkg holds:
  - the default geometry constants;
  - the colour struct/typedef sized by CH_W;
  - an index-width helper function, max(1,$clog2(N)).
- Sub-module vga_sq_hit computes the centre and the registered stage-1 hit for one square. It is instantiated N times via generate.

## Test plan
- Defaults, all squares enabled, colours reset to white. Pixel (row 120, col 160) → white after 2 cycles. Pixel (row 120, col 310) → 0.
- Boundary, square 0. Col 60 and col 260 → hit. Col 59 and col 261 → no hit. Col 0 → no hit and no underflow artefact.
- Write cfg_idx=1, cfg_color=3'b100 mid-frame. The square-1 pixel stays white until frame_start, then becomes red. A same-cycle write plus frame_start → red on the next frame.
- GRID_COLS=3, GRID_ROWS=1, PITCH_X=150. Pixel at col 235 lies in the overlap of squares 0 and 1 → colour of square 0.
- VGA_SQ_BLINK_EN, BLINK_FRAMES=2, blink set on square 2. Square 2 is drawn in frames 0–1, blank in frames 2–3, drawn in frames 4–5.
- Assert rst_n low mid-line → rgb_valid and colour outputs are 0 immediately. After release, the committed table is back to white.

Source files
------------

// File: rtl/vga_square_grid_pkg.sv
// ---------------------------------------------------------------------------
// vga_sq_pkg
// Shared definitions for the square-grid overlay: default geometry, the
// default-width colour record and the index-width helper used to size
// the configuration index port.
// No ports (package).
// ---------------------------------------------------------------------------
package vga_sq_pkg;

  // Default geometry. These values reproduce the legacy 160/460 x 120/340
  // four-square layout.
  localparam int DEF_GRID_COLS    = 2;
  localparam int DEF_GRID_ROWS    = 2;
  localparam int DEF_HSQ_SIZE     = 100;
  localparam int DEF_ORIGIN_X     = 160;
  localparam int DEF_ORIGIN_Y     = 120;
  localparam int DEF_PITCH_X      = 300;
  localparam int DEF_PITCH_Y      = 220;
  localparam int DEF_CH_W         = 1;
  localparam int DEF_BLINK_FRAMES = 30;

  // Pixel coordinates arrive as 11 bits; the hit test widens them to 12 bits
  // so that pixel + HSQ_SIZE can never wrap.
  localparam int COORD_W = 11;
  localparam int CALC_W  = 12;

  // Colour of one square at the default channel width, packed as {r,g,b}.
  typedef struct packed {
    logic [DEF_CH_W-1:0] r;
    logic [DEF_CH_W-1:0] g;
    logic [DEF_CH_W-1:0] b;
  } color_t;

  // Width of an index that can address n entries, never less than one bit.
  function automatic int idxWidth(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vga_square_grid_if.sv
// ---------------------------------------------------------------------------
// vga_sq_if
// Bundles the pixel stream coming from the VGA timing generator, the colour
// configuration port and the RGB output towards the DAC.
//   master : timing generator / CPU side (drives pixel and cfg signals)
//   slave  : the overlay renderer (drives red/green/blue/rgb_valid)
// Parameters: N (number of squares), CH_W (bits per colour channel).
// ---------------------------------------------------------------------------
interface vga_sq_if
  import vga_sq_pkg::*;
#(
  parameter int N    = 4,
  parameter int CH_W = 1
);

  localparam int IDX_W = idxWidth(N);

  logic [COORD_W-1:0] pixel_row;
  logic [COORD_W-1:0] pixel_col;
  logic               pixel_valid;
  logic               frame_start;
  logic [N-1:0]       squares;

  logic               cfg_we;
  logic [IDX_W-1:0]   cfg_idx;
  logic [3*CH_W-1:0]  cfg_color;
  logic               cfg_blink;

  logic [CH_W-1:0]    red;
  logic [CH_W-1:0]    green;
  logic [CH_W-1:0]    blue;
  logic               rgb_valid;

  modport master (
    output pixel_row, pixel_col, pixel_valid, frame_start, squares,
    output cfg_we, cfg_idx, cfg_color, cfg_blink,
    input  red, green, blue, rgb_valid
  );

  modport slave (
    input  pixel_row, pixel_col, pixel_valid, frame_start, squares,
    input  cfg_we, cfg_idx, cfg_color, cfg_blink,
    output red, green, blue, rgb_valid
  );

endinterface

// File: rtl/vga_square_grid_hit.sv
// ---------------------------------------------------------------------------
// vga_sq_hit
// Stage-1 hit detector for a single square of the grid. Works out the
// square's centre from its grid position and registers whether the current
// pixel lies inside the (inclusive) square.
// Ports:
//   clk, rst_n   pixel clock, asynchronous active-low reset
//   pixelRow_i   current pixel row
//   pixelCol_i   current pixel column
//   hit_o        registered hit flag (one cycle after the pixel)
// ---------------------------------------------------------------------------
module vga_sq_hit
  import vga_sq_pkg::*;
#(
  parameter int COL      = 0,
  parameter int ROW      = 0,
  parameter int ORIGIN_X = DEF_ORIGIN_X,
  parameter int ORIGIN_Y = DEF_ORIGIN_Y,
  parameter int PITCH_X  = DEF_PITCH_X,
  parameter int PITCH_Y  = DEF_PITCH_Y,
  parameter int HSQ_SIZE = DEF_HSQ_SIZE
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [COORD_W-1:0] pixelRow_i,
  input  logic [COORD_W-1:0] pixelCol_i,
  output logic               hit_o
);

  localparam logic [CALC_W-1:0] CX  = CALC_W'(ORIGIN_X + COL * PITCH_X);
  localparam logic [CALC_W-1:0] CY  = CALC_W'(ORIGIN_Y + ROW * PITCH_Y);
  localparam logic [CALC_W-1:0] HSQ = CALC_W'(HSQ_SIZE);

  logic [CALC_W-1:0] rowWide;
  logic [CALC_W-1:0] colWide;
  logic              colHit;
  logic              rowHit;
  logic              hit_d;
  logic              hit_q;

  // The HSQ_SIZE is added to the pixel side rather than subtracted from the
  // centre, so squares touching column/row 0 never underflow.
  always_comb begin
    rowWide = {1'b0, pixelRow_i};
    colWide = {1'b0, pixelCol_i};
    colHit  = ((colWide + HSQ) >= CX) && (colWide <= (CX + HSQ));
    rowHit  = ((rowWide + HSQ) >= CY) && (rowWide <= (CY + HSQ));
    hit_d   = colHit && rowHit;
  end

  // Stage-1 register for this square's hit bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q <= 1'b0;
    end else begin
      hit_q <= hit_d;
    end
  end

  assign hit_o = hit_q;

endmodule

// File: rtl/vga_square_grid.sv
// ---------------------------------------------------------------------------
// vga_square_grid
// Square-overlay renderer on the VGA pixel path. Draws a GRID_COLS x
// GRID_ROWS grid of filled squares, each with its own colour from a
// double-buffered colour table (shadow written any time, committed on
// frame_start). Lowest visible square index wins on overlap.
// Two-cycle pipeline: stage 1 registers hit bits, squares and valid;
// stage 2 registers the priority-selected committed colour.
// Optional feature macro: VGA_SQ_BLINK_EN builds the per-square blink bits,
// the frame counter and the blink phase; without it cfg_blink is ignored.
// Ports:
//   clk, rst_n   pixel clock, asynchronous active-low reset
//   bus          vga_sq_if slave: pixel_row/col/valid, frame_start, squares,
//                cfg_we/idx/color/blink in; red/green/blue/rgb_valid out
// ---------------------------------------------------------------------------
module vga_square_grid
  import vga_sq_pkg::*;
#(
  parameter int GRID_COLS    = DEF_GRID_COLS,
  parameter int GRID_ROWS    = DEF_GRID_ROWS,
  parameter int HSQ_SIZE     = DEF_HSQ_SIZE,
  parameter int ORIGIN_X     = DEF_ORIGIN_X,
  parameter int ORIGIN_Y     = DEF_ORIGIN_Y,
  parameter int PITCH_X      = DEF_PITCH_X,
  parameter int PITCH_Y      = DEF_PITCH_Y,
  parameter int CH_W         = DEF_CH_W,
  parameter int BLINK_FRAMES = DEF_BLINK_FRAMES
) (
  input  logic  clk,
  input  logic  rst_n,
  vga_sq_if.slave bus
);

  localparam int N     = GRID_COLS * GRID_ROWS;
  localparam int IDX_W = idxWidth(N);
  localparam int COL_W = 3 * CH_W;

  logic [N-1:0]     hitS1;
  logic [N-1:0]     squares_q;
  logic             valid1_q;
  logic [N-1:0]     wrSel;
  logic [N-1:0]     blinkMask;
  logic [N-1:0]     visible;
  logic [COL_W-1:0] colour_d;
  logic [COL_W-1:0] colour_q;
  logic             rgbValid_q;
  logic             found;

  logic [COL_W-1:0] shadow_q    [N];
  logic [COL_W-1:0] committed_q [N];

  // One hit detector per square; its output is already the stage-1 register.
  for (genvar gi = 0; gi < N; gi++) begin : g_hit
    vga_sq_hit #(
      .COL      (gi % GRID_COLS),
      .ROW      (gi / GRID_COLS),
      .ORIGIN_X (ORIGIN_X),
      .ORIGIN_Y (ORIGIN_Y),
      .PITCH_X  (PITCH_X),
      .PITCH_Y  (PITCH_Y),
      .HSQ_SIZE (HSQ_SIZE)
    ) u_hit (
      .clk        (clk),
      .rst_n      (rst_n),
      .pixelRow_i (bus.pixel_row),
      .pixelCol_i (bus.pixel_col),
      .hit_o      (hitS1[gi])
    );
  end

  // Stage 1: the enable mask travels with the hit bits so a change of
  // squares lines up with the pixel that was sampled alongside it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid1_q  <= 1'b0;
      squares_q <= '0;
    end else begin
      valid1_q  <= bus.pixel_valid;
      squares_q <= bus.squares;
    end
  end

  // Decode the write index; indices at or beyond N select nothing.
  always_comb begin
    wrSel = '0;
    for (int i = 0; i < N; i++) begin
      wrSel[i] = bus.cfg_we && (bus.cfg_idx == IDX_W'(i));
    end
  end

  // Colour table: shadow takes writes at any time, committed copies the whole
  // shadow on frame_start. A write coinciding with frame_start is forwarded
  // so it is not lost until the following frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        shadow_q[i]    <= '1;
        committed_q[i] <= '1;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (bus.frame_start) begin
          committed_q[i] <= shadow_q[i];
        end
        if (wrSel[i]) begin
          shadow_q[i] <= bus.cfg_color;
          if (bus.frame_start) begin
            committed_q[i] <= bus.cfg_color;
          end
        end
      end
    end
  end

`ifdef VGA_SQ_BLINK_EN
  localparam int CNT_W = idxWidth(BLINK_FRAMES);

  logic [N-1:0]     shadowBlink_q;
  logic [N-1:0]     committedBlink_q;
  logic [CNT_W-1:0] frameCnt_q;
  logic             blinkPhase_q;

  // Blink bits follow exactly the same double-buffer rules as the colours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadowBlink_q    <= '0;
      committedBlink_q <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (bus.frame_start) begin
          committedBlink_q[i] <= shadowBlink_q[i];
        end
        if (wrSel[i]) begin
          shadowBlink_q[i] <= bus.cfg_blink;
          if (bus.frame_start) begin
            committedBlink_q[i] <= bus.cfg_blink;
          end
        end
      end
    end
  end

  // Frame counter: phase flips every BLINK_FRAMES frame_start pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frameCnt_q   <= '0;
      blinkPhase_q <= 1'b0;
    end else if (bus.frame_start) begin
      if (frameCnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
        frameCnt_q   <= '0;
        blinkPhase_q <= ~blinkPhase_q;
      end else begin
        frameCnt_q <= frameCnt_q + 1'b1;
      end
    end
  end

  assign blinkMask = committedBlink_q & {N{blinkPhase_q}};
`else
  localparam int unusedBlinkFrames = BLINK_FRAMES;
  logic unusedBlink;
  assign unusedBlink = bus.cfg_blink;
  assign blinkMask   = '0;
`endif

  // Stage 2 select: the first visible square in index order supplies the
  // colour; an invalid pixel is forced to black.
  always_comb begin
    visible  = hitS1 & squares_q & ~blinkMask;
    colour_d = '0;
    found    = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (visible[i] && !found) begin
        colour_d = committed_q[i];
        found    = 1'b1;
      end
    end
    if (!valid1_q) begin
      colour_d = '0;
    end
  end

  // Stage 2 output registers; the async reset blanks the pins immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      colour_q   <= '0;
      rgbValid_q <= 1'b0;
    end else begin
      colour_q   <= colour_d;
      rgbValid_q <= valid1_q;
    end
  end

  assign bus.red       = colour_q[3*CH_W-1 -: CH_W];
  assign bus.green     = colour_q[2*CH_W-1 -: CH_W];
  assign bus.blue      = colour_q[CH_W-1:0];
  assign bus.rgb_valid = rgbValid_q;

endmodule

// File: tb/tb_vga_square_grid.sv
// ---------------------------------------------------------------------------
// tb_vga_square_grid
// Drives two overlay instances from one pixel stream: A uses the default
// 2x2 geometry, B a 3x1 row with 150-pixel pitch (overlapping squares).
// Both use BLINK_FRAMES = 2. A reference model predicts {rgb_valid,r,g,b}
// from the geometry rules; directed pixel checks pin the model to literal
// values. Blink expectations depend on VGA_SQ_BLINK_EN.
// ---------------------------------------------------------------------------
module tb_vga_square_grid;

`ifdef VGA_SQ_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstN;
  logic checkEn = 1'b0;

  logic [10:0] row;
  logic [10:0] col;
  logic        valid;
  logic        frameStart;
  logic [3:0]  squaresA;
  logic [2:0]  squaresB;
  logic        cfgWeA;
  logic        cfgWeB;
  logic [1:0]  cfgIdx;
  logic [2:0]  cfgColor;
  logic        cfgBlink;

  int compared   = 0;
  int mismatched = 0;

  vga_sq_if #(.N(4), .CH_W(1)) busA ();
  vga_sq_if #(.N(3), .CH_W(1)) busB ();

  assign busA.pixel_row   = row;
  assign busA.pixel_col   = col;
  assign busA.pixel_valid = valid;
  assign busA.frame_start = frameStart;
  assign busA.squares     = squaresA;
  assign busA.cfg_we      = cfgWeA;
  assign busA.cfg_idx     = cfgIdx;
  assign busA.cfg_color   = cfgColor;
  assign busA.cfg_blink   = cfgBlink;

  assign busB.pixel_row   = row;
  assign busB.pixel_col   = col;
  assign busB.pixel_valid = valid;
  assign busB.frame_start = frameStart;
  assign busB.squares     = squaresB;
  assign busB.cfg_we      = cfgWeB;
  assign busB.cfg_idx     = cfgIdx;
  assign busB.cfg_color   = cfgColor;
  assign busB.cfg_blink   = cfgBlink;

  vga_square_grid #(.BLINK_FRAMES(2)) dutA (
    .clk   (clk),
    .rst_n (rstN),
    .bus   (busA)
  );

  vga_square_grid #(.GRID_COLS(3), .GRID_ROWS(1), .PITCH_X(150), .BLINK_FRAMES(2)) dutB (
    .clk   (clk),
    .rst_n (rstN),
    .bus   (busB)
  );

  always #5 clk = ~clk;

  // Reference model state: committed/shadow tables per instance, the number
  // of frame_start pulses since reset, the pixel currently in flight and the
  // predicted output word {rgb_valid, r, g, b}.
  logic [2:0]  shCol [2][4];
  logic        shBlk [2][4];
  logic [2:0]  cmCol [2][4];
  logic        cmBlk [2][4];
  int          pulses;
  logic [10:0] s1Row;
  logic [10:0] s1Col;
  logic        s1Valid;
  logic [3:0]  s1SqA;
  logic [3:0]  s1SqB;
  logic [3:0]  expOut [2];

  // Plain geometry: scan squares in index order, return the first visible one.
  function automatic logic [3:0] predict(input int d, input int r, input int c,
                                         input logic v, input logic [3:0] sq);
    int   cols, n, px, cx, cy;
    logic hit, ph;
    cols = (d == 0) ? 2 : 3;
    n    = (d == 0) ? 4 : 3;
    px   = (d == 0) ? 300 : 150;
    ph   = ((pulses / 2) % 2) == 1;
    if (!v) return 4'b0000;
    for (int i = 0; i < n; i++) begin
      cx  = 160 + (i % cols) * px;
      cy  = 120 + (i / cols) * 220;
      hit = (c + 100 >= cx) && (c <= cx + 100) && (r + 100 >= cy) && (r <= cy + 100);
      if (hit && sq[i] && !(BLINK_ON && cmBlk[d][i] && ph)) return {1'b1, cmCol[d][i]};
    end
    return 4'b1000;
  endfunction

  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < 4; i++) begin
          shCol[d][i] <= 3'b111;
          shBlk[d][i] <= 1'b0;
          cmCol[d][i] <= 3'b111;
          cmBlk[d][i] <= 1'b0;
        end
        expOut[d] <= 4'b0000;
      end
      pulses  <= 0;
      s1Row   <= '0;
      s1Col   <= '0;
      s1Valid <= 1'b0;
      s1SqA   <= '0;
      s1SqB   <= '0;
    end else begin
      expOut[0] <= predict(0, int'(s1Row), int'(s1Col), s1Valid, s1SqA);
      expOut[1] <= predict(1, int'(s1Row), int'(s1Col), s1Valid, s1SqB);
      s1Row   <= row;
      s1Col   <= col;
      s1Valid <= valid;
      s1SqA   <= squaresA;
      s1SqB   <= {1'b0, squaresB};
      if (frameStart) begin
        pulses <= pulses + 1;
        for (int d = 0; d < 2; d++) begin
          for (int i = 0; i < 4; i++) begin
            cmCol[d][i] <= shCol[d][i];
            cmBlk[d][i] <= shBlk[d][i];
          end
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (cfgWeA && int'(cfgIdx) == i) begin
          shCol[0][i] <= cfgColor;
          shBlk[0][i] <= cfgBlink;
          if (frameStart) begin
            cmCol[0][i] <= cfgColor;
            cmBlk[0][i] <= cfgBlink;
          end
        end
        if (cfgWeB && int'(cfgIdx) == i && i < 3) begin
          shCol[1][i] <= cfgColor;
          shBlk[1][i] <= cfgBlink;
          if (frameStart) begin
            cmCol[1][i] <= cfgColor;
            cmBlk[1][i] <= cfgBlink;
          end
        end
      end
    end
  end

  // Single comparison point shared by the model check and the literal checks.
  task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] outA();
    return {busA.rgb_valid, busA.red, busA.green, busA.blue};
  endfunction

  function automatic logic [3:0] outB();
    return {busB.rgb_valid, busB.red, busB.green, busB.blue};
  endfunction

  // Every cycle, away from the rising edge, both instances against the model.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("modelA", outA(), expOut[0]);
      checkOutput("modelB", outB(), expOut[1]);
    end
  end

  // Present one pixel and hold it until it has crossed both pipeline stages.
  task automatic applyStimulus(input int r, input int c, input logic v);
    @(negedge clk);
    row   = 11'(r);
    col   = 11'(c);
    valid = v;
    @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic pixelCheck(input string name, input int d, input int r, input int c,
                            input logic v, input logic [3:0] exp);
    applyStimulus(r, c, v);
    checkOutput(name, (d == 0) ? outA() : outB(), exp);
  endtask

  task automatic cfgWrite(input int d, input int idx, input logic [2:0] colour,
                          input logic blink, input logic withFrame);
    @(negedge clk);
    cfgWeA     = (d == 0);
    cfgWeB     = (d == 1);
    cfgIdx     = 2'(idx);
    cfgColor   = colour;
    cfgBlink   = blink;
    frameStart = withFrame;
    @(negedge clk);
    cfgWeA     = 1'b0;
    cfgWeB     = 1'b0;
    frameStart = 1'b0;
  endtask

  task automatic pulseFrame();
    @(negedge clk);
    frameStart = 1'b1;
    @(negedge clk);
    frameStart = 1'b0;
  endtask

  initial begin
    rstN       = 1'b1;
    row        = '0;
    col        = '0;
    valid      = 1'b0;
    frameStart = 1'b0;
    squaresA   = 4'b1111;
    squaresB   = 3'b111;
    cfgWeA     = 1'b0;
    cfgWeB     = 1'b0;
    cfgIdx     = '0;
    cfgColor   = '0;
    cfgBlink   = 1'b0;
    #1 rstN = 1'b0;
    #1 checkEn = 1'b1;
    checkOutput("reset_A", outA(), 4'b0000);
    checkOutput("reset_B", outB(), 4'b0000);
    repeat (2) @(negedge clk);
    rstN = 1'b1;

    $display("[TB] geometry and boundaries");
    pixelCheck("centre_white", 0, 120, 160, 1'b1, 4'b1111);
    pixelCheck("gap_black",    0, 120, 310, 1'b1, 4'b1000);
    pixelCheck("col60_hit",    0, 120, 60,  1'b1, 4'b1111);
    pixelCheck("col260_hit",   0, 120, 260, 1'b1, 4'b1111);
    pixelCheck("col59_miss",   0, 120, 59,  1'b1, 4'b1000);
    pixelCheck("col261_miss",  0, 120, 261, 1'b1, 4'b1000);
    pixelCheck("col0_miss",    0, 120, 0,   1'b1, 4'b1000);
    pixelCheck("invalid_pix",  0, 120, 160, 1'b0, 4'b0000);
    squaresA = 4'b1110;
    pixelCheck("sq0_disabled", 0, 120, 160, 1'b1, 4'b1000);
    squaresA = 4'b1111;

    $display("[TB] double-buffered colour table");
    cfgWrite(0, 1, 3'b100, 1'b0, 1'b0);
    pixelCheck("sq1_pre_commit",  0, 120, 460, 1'b1, 4'b1111);
    pulseFrame();
    pixelCheck("sq1_red",         0, 120, 460, 1'b1, 4'b1100);
    cfgWrite(0, 3, 3'b010, 1'b0, 1'b1);
    pixelCheck("sq3_forwarded",   0, 340, 460, 1'b1, 4'b1010);
    pulseFrame();
    pixelCheck("sq3_kept",        0, 340, 460, 1'b1, 4'b1010);

    $display("[TB] overlap priority");
    cfgWrite(1, 0, 3'b100, 1'b0, 1'b0);
    cfgWrite(1, 1, 3'b001, 1'b0, 1'b0);
    cfgWrite(1, 3, 3'b010, 1'b0, 1'b0);
    pulseFrame();
    pixelCheck("overlap_sq0", 1, 120, 235, 1'b1, 4'b1100);
    pixelCheck("only_sq1",    1, 120, 300, 1'b1, 4'b1001);
    squaresB = 3'b110;
    pixelCheck("overlap_sq1", 1, 120, 235, 1'b1, 4'b1001);
    squaresB = 3'b111;

    $display("[TB] reset mid-line");
    @(negedge clk);
    row   = 11'd120;
    col   = 11'd460;
    valid = 1'b1;
    repeat (2) @(posedge clk);
    #3 rstN = 1'b0;
    #1;
    checkOutput("midreset_A", outA(), 4'b0000);
    checkOutput("midreset_B", outB(), 4'b0000);
    @(negedge clk);
    rstN = 1'b1;
    pixelCheck("post_reset_white", 0, 120, 460, 1'b1, 4'b1111);

    $display("[TB] blink");
    cfgWrite(0, 2, 3'b111, 1'b1, 1'b0);
    pixelCheck("blink_f0", 0, 340, 160, 1'b1, 4'b1111);
    pulseFrame();
    pixelCheck("blink_f1", 0, 340, 160, 1'b1, 4'b1111);
    pulseFrame();
    pixelCheck("blink_f2", 0, 340, 160, 1'b1, BLINK_ON ? 4'b1000 : 4'b1111);
    pulseFrame();
    pixelCheck("blink_f3", 0, 340, 160, 1'b1, BLINK_ON ? 4'b1000 : 4'b1111);
    pixelCheck("blink_f3_sq0", 0, 120, 160, 1'b1, 4'b1111);
    pulseFrame();
    pixelCheck("blink_f4", 0, 340, 160, 1'b1, 4'b1111);
    pulseFrame();
    pixelCheck("blink_f5", 0, 340, 160, 1'b1, 4'b1111);

    repeat (3) @(negedge clk);
    checkEn = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
